// File: rtl/lfsr8_model.sv
// 8-bit Fibonacci LFSR: seed and tap mask are captured on the first edge after reset,
// then the register shifts left once per clock with XOR-reduced tapped feedback into bit 0.
module lfsr8_model (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] din,
  input  logic [7:0] tap,
  output logic [7:0] dout
);

  logic [7:0] state_q, state_d;
  logic [7:0] tap_q, tap_d;
  logic       loaded_q, loaded_d;
  logic       fb;

  always_comb begin
    fb       = ^(state_q & tap_q);
    state_d  = state_q;
    tap_d    = tap_q;
    loaded_d = loaded_q;
    if (!loaded_q) begin
      // Load edge: capture seed and taps, no shift on this cycle.
      state_d  = din;
      tap_d    = tap;
      loaded_d = 1'b1;
    end else begin
      state_d  = {state_q[6:0], fb};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= 8'h00;
      tap_q    <= 8'h00;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      loaded_q <= loaded_d;
    end
  end

  assign dout = state_q;

endmodule

// File: tb/tb_lfsr8_model.sv
// Self-checking bench for lfsr8_model: directed sequences plus randomized seeds/taps
// compared against an arithmetic reference of the shift-and-parity rule.
module tb_lfsr8_model;

  logic       clk;
  logic       resetn;
  logic [7:0] din;
  logic [7:0] tap;
  logic [7:0] dout;

  int tests_run    = 0;
  int tests_failed = 0;

  lfsr8_model dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .tap    (tap),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift left, new bit 0 is the parity of the tapped bits.
  function automatic logic [7:0] ref_next(input logic [7:0] s, input logic [7:0] t);
    int ones;
    ones = $countones(s & t);
    return ((s << 1) & 8'hFF) | 8'(ones % 2);
  endfunction

  task automatic step_sample();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check async clear, release on a falling edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL %s_async_clear: dout=%02h expected=00", tag, dout);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    din    = 8'h01;
    tap    = 8'h0E;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (dout !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: dout=%02h expected=00", i, dout);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic run_known_seq(input string tag, input bit freeze_inputs);
    logic [7:0] exp_seq [11];
    exp_seq = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB1, 8'h62, 8'hC5, 8'h8B};
    din = 8'h01;
    tap = 8'h0E;
    apply_reset(tag);
    for (int i = 0; i < 11; i++) begin
      step_sample();
      if (freeze_inputs && i == 0) begin
        din = 8'hFF;
        tap = 8'h00;
      end
      tests_run++;
      if (dout !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL %s[%0d]: dout=%02h expected=%02h", tag, i, dout, exp_seq[i]);
      end
    end
    $display("[TB] %s done", tag);
  endtask

  task automatic test_sequence();
    run_known_seq("seq", 1'b0);
  endtask

  task automatic test_input_freeze();
    run_known_seq("freeze", 1'b1);
  endtask

  task automatic test_midrun_reset();
    logic [7:0] exp_seq [3];
    exp_seq = '{8'h01, 8'h02, 8'h05};
    din = 8'h01;
    tap = 8'h0E;
    apply_reset("midrun_pre");
    repeat (6) step_sample();
    tests_run++;
    if (dout !== 8'h2C) begin
      tests_failed++;
      $display("FAIL midrun_before: dout=%02h expected=2C", dout);
    end
    apply_reset("midrun");
    for (int i = 0; i < 3; i++) begin
      step_sample();
      tests_run++;
      if (dout !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL midrun_restart[%0d]: dout=%02h expected=%02h", i, dout, exp_seq[i]);
      end
    end
    $display("[TB] test_midrun_reset done");
  endtask

  task automatic test_degenerate();
    logic [7:0] exp_seq [12];
    exp_seq = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80,
                8'h00, 8'h00, 8'h00, 8'h00};
    din = 8'h00;
    tap = 8'($urandom_range(255));
    apply_reset("zero_seed");
    for (int i = 0; i < 20; i++) begin
      step_sample();
      tests_run++;
      if (dout !== 8'h00) begin
        tests_failed++;
        $display("FAIL zero_seed[%0d]: dout=%02h expected=00", i, dout);
      end
    end
    din = 8'hA5;
    tap = 8'h00;
    apply_reset("zero_tap");
    for (int i = 0; i < 12; i++) begin
      step_sample();
      tests_run++;
      if (dout !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL zero_tap[%0d]: dout=%02h expected=%02h", i, dout, exp_seq[i]);
      end
    end
    $display("[TB] test_degenerate done");
  endtask

  task automatic test_maximal();
    int first_return;
    int zero_hits;
    first_return = -1;
    zero_hits    = 0;
    din = 8'h01;
    tap = 8'hB8;
    apply_reset("maximal");
    step_sample();
    for (int i = 1; i <= 255; i++) begin
      step_sample();
      if (dout === 8'h00) zero_hits++;
      if (dout === 8'h01 && first_return < 0) first_return = i;
    end
    tests_run++;
    if (first_return != 255) begin
      tests_failed++;
      $display("FAIL maximal_period: first_return=%0d expected=255", first_return);
    end
    tests_run++;
    if (zero_hits != 0) begin
      tests_failed++;
      $display("FAIL maximal_no_zero: zero_hits=%0d expected=0", zero_hits);
    end
    $display("[TB] test_maximal done period=%0d", first_return);
  endtask

  task automatic test_random();
    logic [7:0] seed;
    logic [7:0] taps;
    logic [7:0] model;
    int         errs;
    for (int trial = 0; trial < 6; trial++) begin
      seed = 8'($urandom_range(255));
      taps = 8'($urandom_range(255));
      din  = seed;
      tap  = taps;
      apply_reset("random");
      model = seed;
      errs  = 0;
      for (int i = 0; i < 40; i++) begin
        step_sample();
        din = 8'($urandom_range(255));
        tap = 8'($urandom_range(255));
        tests_run++;
        if (dout !== model) begin
          tests_failed++;
          errs++;
          $display("FAIL random[%0d][%0d] seed=%02h tap=%02h: dout=%02h expected=%02h",
                   trial, i, seed, taps, dout, model);
        end
        model = ref_next(model, taps);
      end
      $display("[TB] random trial %0d seed=%02h tap=%02h errors=%0d", trial, seed, taps, errs);
    end
  endtask

  initial begin
    resetn = 1'b0;
    din    = 8'h00;
    tap    = 8'h00;
    test_reset();
    test_sequence();
    test_input_freeze();
    test_midrun_reset();
    test_degenerate();
    test_maximal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
